sfm_pass_scheduler: RTL and testbench
=====================================

# sfm_pass_scheduler

Two-pass sequencer for the softmax accelerator, sitting between the job register file and the streamer/datapath pair. For each job it runs an accumulation pass: read the input vector, and the datapath computes the running max and the sum of exponentials. After the datapath reports that its accumulator has been reduced, it runs a normalisation pass: re-read the input and write the normalised output. It issues streamer requests, counts accepted beats, drives the datapath mode and last-beat marker, and signals job completion.

## Interface
- DATA_WIDTH, 128, streamer beat width in bits
- ELEM_WIDTH, 16, element width in bits; VECT = DATA_WIDTH/ELEM_WIDTH elements per beat
- ADDR_WIDTH, 32, byte-address width
- LEN_WIDTH, 16, element-count width
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- start_i  in  1  job start pulse
- in_addr_i / out_addr_i  in  ADDR_WIDTH  input/output base addresses
- len_i  in  LEN_WIDTH  job length in elements
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion pulse
- in_req_valid_o / in_req_ready_i  out/in  1  input-stream request handshake
- in_req_addr_o  out  ADDR_WIDTH  input request base address
- in_req_beats_o  out  LEN_WIDTH  input request length in beats
- out_req_valid_o / out_req_ready_i / out_req_addr_o / out_req_beats_o  same fields, output stream
- last_strb_o  out  VECT  element mask for the final beat
- in_beat_i  in  1  input beat consumed by datapath (valid&ready)
- out_beat_i  in  1  output beat accepted by streamer
- dp_mode_o  out  2  0 IDLE, 1 ACC, 2 NORM
- dp_last_o  out  1  current input beat is the last of the pass
- dp_acc_done_i  in  1  datapath denominator ready
- perf_busy_o / perf_stall_o  out  32  performance counters

## Operation
- On start in IDLE:
  - beats = ceil(len_i/VECT).
  - last_strb = all ones if len_i%VECT==0; otherwise the low (len_i%VECT) bits are set.
  - Addresses, beats and last_strb are latched.
- FSM states: IDLE, ACC_REQ, ACC_RUN, ACC_WAIT, NORM_REQ, NORM_RUN, DONE.
- IDLE:
  - start_i with len_i!=0 goes to ACC_REQ.
  - start_i with len_i==0 goes to DONE, with no requests issued.
- ACC_REQ: in_req_valid_o held high. On in_req_ready_i, go to ACC_RUN.
- ACC_RUN: go to ACC_WAIT when in_cnt reaches beats.
- ACC_WAIT:
  - dp_acc_done_i goes to NORM_REQ; in_cnt is reset.
  - dp_acc_done_i outside ACC_WAIT is ignored.
- NORM_REQ:
  - in_req_valid_o and out_req_valid_o are raised together.
  - Each stays high until its own ready is seen; a done flag is kept per request.
  - Go to NORM_RUN when both are accepted, including when both are accepted in the same cycle.
- NORM_RUN: go to DONE when out_cnt reaches beats.
- DONE: done_o=1 for one cycle, then IDLE.
- Beat counting:
  - in_beat_i/out_beat_i increment in_cnt/out_cnt in any non-IDLE state, so beats arriving in a REQ state still count.
  - Counters saturate at beats.
- Outputs by state:
  - dp_mode_o = ACC in ACC_REQ/ACC_RUN/ACC_WAIT; NORM in NORM_REQ/NORM_RUN; IDLE otherwise.
  - dp_last_o = busy & (in_cnt == beats-1) & (mode != IDLE).
  - busy_o = (state != IDLE).
- start_i while busy is ignored.
- clear_i forces IDLE and zeroes all counters, latches and request flags. done_o is not pulsed.
- Reset values: all outputs 0, dp_mode_o=IDLE, perf counters 0.

## Timing
- Moore outputs from registered state.
- dp_last_o is combinational from registered counters.
- start_i -> in_req_valid_o high in the next cycle.
- Last out_beat_i in cycle N -> done_o in N+1 -> busy_o low in N+2.
- dp_acc_done_i in cycle N -> both req valids high in N+1.
- len_i==0: done_o in the cycle after start_i.
- Async reset mid-job: every output returns to its reset value immediately; no request is re-issued.

## Configuration
- Macro SFM_SCHED_PERF_EN.
- Defined:
  - perf_busy_o counts cycles with busy_o=1.
  - perf_stall_o counts ACC_RUN/NORM_RUN cycles with no beat event for the pass's counted stream (in for ACC, out for NORM).
  - Both wrap at 2^32, are zeroed on start acceptance and clear_i, and hold their value after done.
- Undefined: ports remain, tied to 0, and no counter flops are present.

## Structure
- sfm_pkg holds:
  - sched_state_e
  - dp_mode_e (2-bit)
  - the SFM_DP_MODE_* encodings
- Sub-module sfm_beat_counter:
  - Saturating up-counter with clear, enable, limit, and an at_limit/at_limit_minus_one flag pair.
  - Instanced twice (in_cnt, out_cnt).

## Test plan
- len=16, VECT=8, readies immediate, one beat per cycle:
  - in_req_beats_o=2 in ACC and again in NORM; last_strb_o=0xFF.
  - dp_last_o high on in beats 2 and 4.
  - done_o one cycle after the 2nd out beat.
- len=13:
  - beats=2, last_strb_o=0x1F.
  - FSM holds in ACC_WAIT until dp_acc_done_i is driven 10 cycles later, then both requests rise.
- len=0: done_o in the cycle after start_i; no req valid ever asserted; busy_o high exactly one cycle.
- NORM_REQ with out_req_ready_i delayed 5 cycles after in_req_ready_i, plus 2 input beats arriving meanwhile:
  - in_req_valid_o drops after 1 cycle; out_req_valid_o is held.
  - in_cnt=2 on entry to NORM_RUN.
- clear_i asserted in ACC_RUN after 1 of 4 beats:
  - Next cycle: IDLE, busy_o=0, no done_o.
  - A new start with len=8 runs a full clean job.
- start_i pulsed during NORM_RUN: ignored, latched len unchanged. With SFM_SCHED_PERF_EN, a 3-beat stall in NORM_RUN gives perf_stall_o=3.

Source files
------------

// File: rtl/sfm_pkg.sv
// -----------------------------------------------------------------------------
// sfm_pkg
// Shared types for the softmax pass scheduler: sequencer state encoding,
// datapath mode encoding and a helper that maps a sequencer state to the
// datapath mode it implies.
// -----------------------------------------------------------------------------
package sfm_pkg;

  localparam logic [1:0] SFM_DP_MODE_IDLE = 2'd0;
  localparam logic [1:0] SFM_DP_MODE_ACC  = 2'd1;
  localparam logic [1:0] SFM_DP_MODE_NORM = 2'd2;

  typedef enum logic [1:0] {
    DP_MODE_IDLE = SFM_DP_MODE_IDLE,
    DP_MODE_ACC  = SFM_DP_MODE_ACC,
    DP_MODE_NORM = SFM_DP_MODE_NORM
  } dp_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_REQ,
    S_ACC_RUN,
    S_ACC_WAIT,
    S_NORM_REQ,
    S_NORM_RUN,
    S_DONE
  } sched_state_e;

  function automatic dp_mode_e mode_of_state(input sched_state_e s);
    case (s)
      S_ACC_REQ, S_ACC_RUN, S_ACC_WAIT: return DP_MODE_ACC;
      S_NORM_REQ, S_NORM_RUN:           return DP_MODE_NORM;
      default:                          return DP_MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sfm_beat_counter.sv
// -----------------------------------------------------------------------------
// sfm_beat_counter
// Saturating beat counter. Counts enabled cycles up to limit_i and then holds.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous clear (wins over enable)
//   en_i               count one beat
//   limit_i            saturation value
//   at_limit_o         count == limit
//   at_limit_m1_o      count == limit - 1 (next beat reaches the limit)
// -----------------------------------------------------------------------------
module sfm_beat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             at_limit_o,
  output logic             at_limit_m1_o
);

  logic [WIDTH-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (en_i && !at_limit_o) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign at_limit_o    = (r_cnt == limit_i);
  assign at_limit_m1_o = (r_cnt == (limit_i - WIDTH'(1)));

endmodule

// File: rtl/sfm_pass_scheduler.sv
// -----------------------------------------------------------------------------
// sfm_pass_scheduler
// Two-pass job sequencer for the softmax accelerator: an accumulation pass
// (read input, datapath builds max / sum of exponentials) followed, once the
// datapath reports its denominator, by a normalisation pass (re-read input,
// write output).
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   clear_i                       synchronous soft clear
//   start_i, in_addr_i,
//   out_addr_i, len_i             job launch and parameters (elements)
//   busy_o, done_o                job status / one-cycle completion pulse
//   in_req_*, out_req_*           streamer request handshakes
//   last_strb_o                   element mask of the final beat
//   in_beat_i, out_beat_i         accepted beats per stream
//   dp_mode_o, dp_last_o          datapath mode and last-input-beat marker
//   dp_acc_done_i                 datapath denominator ready
//   perf_busy_o, perf_stall_o     performance counters
// Build option: define SFM_SCHED_PERF_EN to implement the performance
// counters; otherwise the perf ports are tied to zero.
// -----------------------------------------------------------------------------
module sfm_pass_scheduler
  import sfm_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ELEM_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  localparam int VECT      = DATA_WIDTH / ELEM_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [ADDR_WIDTH-1:0] out_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  in_req_valid_o,
  input  logic                  in_req_ready_i,
  output logic [ADDR_WIDTH-1:0] in_req_addr_o,
  output logic [LEN_WIDTH-1:0]  in_req_beats_o,
  output logic                  out_req_valid_o,
  input  logic                  out_req_ready_i,
  output logic [ADDR_WIDTH-1:0] out_req_addr_o,
  output logic [LEN_WIDTH-1:0]  out_req_beats_o,
  output logic [VECT-1:0]       last_strb_o,
  input  logic                  in_beat_i,
  input  logic                  out_beat_i,
  output logic [1:0]            dp_mode_o,
  output logic                  dp_last_o,
  input  logic                  dp_acc_done_i,
  output logic [31:0]           perf_busy_o,
  output logic [31:0]           perf_stall_o
);

  localparam int VECT_LOG2 = $clog2(VECT);

  sched_state_e          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_in_addr, r_out_addr;
  logic [LEN_WIDTH-1:0]  r_beats;
  logic [VECT-1:0]       r_last_strb;
  logic                  r_in_req_done, r_out_req_done;

  logic                  w_busy, w_start_acc, w_norm_go;
  logic                  w_in_reach, w_out_reach, w_in_clr, w_out_clr;
  logic                  w_in_at_lim, w_in_at_lim_m1, w_out_at_lim, w_out_at_lim_m1;
  logic [VECT_LOG2-1:0]  w_rem;
  logic [LEN_WIDTH-1:0]  w_beats;
  logic [VECT-1:0]       w_last_strb;
  dp_mode_e              w_mode;

  // ---------------------------------------------------------------------------
  // Job geometry: beats = ceil(len / VECT), final-beat element mask.
  // ---------------------------------------------------------------------------
  assign w_rem   = len_i[VECT_LOG2-1:0];
  assign w_beats = (len_i >> VECT_LOG2) + {{(LEN_WIDTH-1){1'b0}}, (w_rem != '0)};

  always_comb begin
    w_last_strb = '0;
    for (int k = 0; k < VECT; k++) begin
      w_last_strb[k] = (w_rem == '0) || (k < int'(w_rem));
    end
  end

  // ---------------------------------------------------------------------------
  // Control terms
  // ---------------------------------------------------------------------------
  assign w_busy      = (r_state != S_IDLE);
  assign w_start_acc = (r_state == S_IDLE) && start_i && !clear_i;

  // The pass ends on the beat that reaches the limit, so completion lines up
  // with the cycle after the final beat rather than one cycle later.
  assign w_in_reach  = w_in_at_lim  || (in_beat_i  && w_in_at_lim_m1);
  assign w_out_reach = w_out_at_lim || (out_beat_i && w_out_at_lim_m1);

  // Both normalisation requests accepted, now or in an earlier cycle.
  assign w_norm_go = (r_in_req_done || in_req_ready_i) &&
                     (r_out_req_done || out_req_ready_i);

  // The input counter restarts for the second read of the vector.
  assign w_in_clr  = clear_i || w_start_acc ||
                     ((r_state == S_ACC_WAIT) && dp_acc_done_i);
  assign w_out_clr = clear_i || w_start_acc;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: holding the current state as the first assignment gives every path
  // a value, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start_i) w_state_nxt = (len_i == '0) ? S_DONE : S_ACC_REQ;
      S_ACC_REQ:  if (in_req_ready_i) w_state_nxt = S_ACC_RUN;
      S_ACC_RUN:  if (w_in_reach) w_state_nxt = S_ACC_WAIT;
      S_ACC_WAIT: if (dp_acc_done_i) w_state_nxt = S_NORM_REQ;
      S_NORM_REQ: if (w_norm_go) w_state_nxt = S_NORM_RUN;
      S_NORM_RUN: if (w_out_reach) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (clear_i) w_state_nxt = S_IDLE;
  end

  // Job parameters are captured only when a job is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_addr   <= '0;
      r_out_addr  <= '0;
      r_beats     <= '0;
      r_last_strb <= '0;
    end else if (clear_i) begin
      r_in_addr   <= '0;
      r_out_addr  <= '0;
      r_beats     <= '0;
      r_last_strb <= '0;
    end else if (w_start_acc) begin
      r_in_addr   <= in_addr_i;
      r_out_addr  <= out_addr_i;
      r_beats     <= w_beats;
      r_last_strb <= w_last_strb;
    end
  end

  // Per-request acceptance flags, live only while in NORM_REQ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_req_done  <= 1'b0;
      r_out_req_done <= 1'b0;
    end else begin
      r_in_req_done  <= (r_state == S_NORM_REQ) && !w_norm_go && !clear_i &&
                        (r_in_req_done || in_req_ready_i);
      r_out_req_done <= (r_state == S_NORM_REQ) && !w_norm_go && !clear_i &&
                        (r_out_req_done || out_req_ready_i);
    end
  end

  // ---------------------------------------------------------------------------
  // Beat counters
  // ---------------------------------------------------------------------------
  sfm_beat_counter #(.WIDTH(LEN_WIDTH)) u_in_cnt (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (w_in_clr),
    .en_i          (w_busy && in_beat_i),
    .limit_i       (r_beats),
    .at_limit_o    (w_in_at_lim),
    .at_limit_m1_o (w_in_at_lim_m1)
  );

  sfm_beat_counter #(.WIDTH(LEN_WIDTH)) u_out_cnt (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (w_out_clr),
    .en_i          (w_busy && out_beat_i),
    .limit_i       (r_beats),
    .at_limit_o    (w_out_at_lim),
    .at_limit_m1_o (w_out_at_lim_m1)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_mode          = mode_of_state(r_state);
  assign dp_mode_o       = w_mode;
  assign busy_o          = w_busy;
  assign done_o          = (r_state == S_DONE);
  assign in_req_valid_o  = (r_state == S_ACC_REQ) ||
                           ((r_state == S_NORM_REQ) && !r_in_req_done);
  assign out_req_valid_o = (r_state == S_NORM_REQ) && !r_out_req_done;
  assign in_req_addr_o   = r_in_addr;
  assign out_req_addr_o  = r_out_addr;
  assign in_req_beats_o  = r_beats;
  assign out_req_beats_o = r_beats;
  assign last_strb_o     = r_last_strb;
  assign dp_last_o       = w_busy && w_in_at_lim_m1 && (w_mode != DP_MODE_IDLE);

`ifdef SFM_SCHED_PERF_EN
  logic [31:0] r_perf_busy, r_perf_stall;
  logic        w_stall;

  // A stall is a run-phase cycle without a beat on the stream that pass counts.
  assign w_stall = ((r_state == S_ACC_RUN)  && !in_beat_i) ||
                   ((r_state == S_NORM_RUN) && !out_beat_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else if (clear_i || w_start_acc) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_busy)  r_perf_busy  <= r_perf_busy  + 32'd1;
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_busy_o  = r_perf_busy;
  assign perf_stall_o = r_perf_stall;
`else
  assign perf_busy_o  = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_sfm_pass_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sfm_pass_scheduler
// Self-checking bench for sfm_pass_scheduler. Drives jobs through both passes
// with directed and randomised handshake timing; expected values come from
// job-level arithmetic (beats, masks, cycle counts) held in the bench.
// -----------------------------------------------------------------------------
module tb_sfm_pass_scheduler;
  import sfm_pkg::*;

  localparam int DW   = 128;
  localparam int EW   = 16;
  localparam int AW   = 32;
  localparam int LW   = 16;
  localparam int VECT = DW / EW;

  logic            clk_i = 1'b0;
  logic            rst_ni, clear_i, start_i;
  logic [AW-1:0]   in_addr_i, out_addr_i;
  logic [LW-1:0]   len_i;
  logic            busy_o, done_o;
  logic            in_req_valid_o, in_req_ready_i;
  logic [AW-1:0]   in_req_addr_o;
  logic [LW-1:0]   in_req_beats_o;
  logic            out_req_valid_o, out_req_ready_i;
  logic [AW-1:0]   out_req_addr_o;
  logic [LW-1:0]   out_req_beats_o;
  logic [VECT-1:0] last_strb_o;
  logic            in_beat_i, out_beat_i;
  logic [1:0]      dp_mode_o;
  logic            dp_last_o, dp_acc_done_i;
  logic [31:0]     perf_busy_o, perf_stall_o;

  always #5 clk_i = ~clk_i;

  sfm_pass_scheduler #(
    .DATA_WIDTH(DW), .ELEM_WIDTH(EW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .start_i         (start_i),
    .in_addr_i       (in_addr_i),
    .out_addr_i      (out_addr_i),
    .len_i           (len_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .in_req_valid_o  (in_req_valid_o),
    .in_req_ready_i  (in_req_ready_i),
    .in_req_addr_o   (in_req_addr_o),
    .in_req_beats_o  (in_req_beats_o),
    .out_req_valid_o (out_req_valid_o),
    .out_req_ready_i (out_req_ready_i),
    .out_req_addr_o  (out_req_addr_o),
    .out_req_beats_o (out_req_beats_o),
    .last_strb_o     (last_strb_o),
    .in_beat_i       (in_beat_i),
    .out_beat_i      (out_beat_i),
    .dp_mode_o       (dp_mode_o),
    .dp_last_o       (dp_last_o),
    .dp_acc_done_i   (dp_acc_done_i),
    .perf_busy_o     (perf_busy_o),
    .perf_stall_o    (perf_stall_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference bookkeeping: expected perf counts, and which kind of cycle the
  // DUT is in from the environment's point of view.
  int exp_pbusy  = 0;
  int exp_pstall = 0;
  bit m_busy     = 1'b0;
  int m_run      = 0;   // 0 none, 1 accumulation run, 2 normalisation run

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_beats(input int len);
    return (len + VECT - 1) / VECT;
  endfunction

  function automatic logic [VECT-1:0] m_strb(input int len);
    if (len % VECT == 0) return '1;
    return VECT'((1 << (len % VECT)) - 1);
  endfunction

  // Account for the cycle being left (using the inputs currently driven),
  // then advance to the next sampling point.
  task automatic tick();
    if (m_busy) exp_pbusy++;
    if ((m_run == 1 && !in_beat_i) || (m_run == 2 && !out_beat_i)) exp_pstall++;
    @(negedge clk_i);
  endtask

  task automatic check_perf(input string tag);
`ifdef SFM_SCHED_PERF_EN
    check({tag, "_pbusy"},  perf_busy_o,  exp_pbusy);
    check({tag, "_pstall"}, perf_stall_o, exp_pstall);
`else
    check({tag, "_pbusy"},  perf_busy_o,  0);
    check({tag, "_pstall"}, perf_stall_o, 0);
`endif
  endtask

  // One complete job. Gaps < 0 pick a random 0..2 idle cycles per beat.
  task automatic run_job(input int len, input int rdy_dly, input int out_extra,
                         input int acc_dly, input int acc_gap, input int norm_gap,
                         input bit poke);
    int              beats, in_sent, out_sent, npre, g;
    logic [VECT-1:0] strb;
    logic [AW-1:0]   ia, oa;
    beats = m_beats(len);
    strb  = m_strb(len);
    ia    = $urandom;
    oa    = $urandom;

    start_i = 1'b1; len_i = LW'(len); in_addr_i = ia; out_addr_i = oa;
    exp_pbusy = 0; exp_pstall = 0; m_run = 0; m_busy = 1'b0;
    tick();
    start_i = 1'b0; len_i = LW'($urandom); in_addr_i = $urandom; out_addr_i = $urandom;
    m_busy = 1'b1;
    check("busy_after_start", busy_o, 1);

    if (len == 0) begin
      check("zero_done",      done_o, 1);
      check("zero_in_valid",  in_req_valid_o, 0);
      check("zero_out_valid", out_req_valid_o, 0);
      tick();
      m_busy = 1'b0;
      check("zero_busy_low",  busy_o, 0);
      check("zero_done_low",  done_o, 0);
      check("zero_in_valid2", in_req_valid_o, 0);
      check_perf("zero");
      return;
    end

    // Accumulation request
    check("acc_valid",     in_req_valid_o, 1);
    check("acc_out_valid", out_req_valid_o, 0);
    check("acc_mode",      dp_mode_o, SFM_DP_MODE_ACC);
    check("acc_addr",      in_req_addr_o, ia);
    check("acc_beats",     in_req_beats_o, beats);
    check("acc_strb",      last_strb_o, strb);
    repeat (rdy_dly) begin
      tick();
      check("acc_valid_hold", in_req_valid_o, 1);
    end
    in_req_ready_i = 1'b1;
    tick();
    in_req_ready_i = 1'b0;
    m_run = 1;
    check("acc_valid_drop", in_req_valid_o, 0);

    // Accumulation beats
    in_sent = 0;
    while (in_sent < beats) begin
      g = (acc_gap < 0) ? int'($urandom_range(2, 0)) : acc_gap;
      repeat (g) tick();
      in_beat_i = 1'b1;
      check("acc_last", dp_last_o, (in_sent == beats - 1));
      tick();
      in_beat_i = 1'b0;
      in_sent++;
    end
    m_run = 0;

    // Waiting for the denominator
    check("wait_mode",  dp_mode_o, SFM_DP_MODE_ACC);
    check("wait_last",  dp_last_o, 0);
    check("wait_valid", in_req_valid_o | out_req_valid_o, 0);
    repeat (acc_dly) tick();
    check("wait_hold_mode",  dp_mode_o, SFM_DP_MODE_ACC);
    check("wait_hold_valid", in_req_valid_o | out_req_valid_o, 0);
    dp_acc_done_i = 1'b1;
    tick();
    dp_acc_done_i = 1'b0;

    // Normalisation requests
    check("norm_in_valid",  in_req_valid_o, 1);
    check("norm_out_valid", out_req_valid_o, 1);
    check("norm_mode",      dp_mode_o, SFM_DP_MODE_NORM);
    check("norm_in_beats",  in_req_beats_o, beats);
    check("norm_out_beats", out_req_beats_o, beats);
    check("norm_out_addr",  out_req_addr_o, oa);
    in_sent = 0;
    npre = (out_extra < 2) ? out_extra : 2;
    if (npre > beats) npre = beats;
    for (int k = 0; k <= out_extra; k++) begin
      in_req_ready_i  = (k == 0);
      out_req_ready_i = (k == out_extra);
      in_beat_i       = (k >= 1 && k <= npre);
      if (k >= 1) begin
        check("nreq_in_drop",  in_req_valid_o, 0);
        check("nreq_out_hold", out_req_valid_o, 1);
      end
      if (in_beat_i) check("nreq_last", dp_last_o, (in_sent == beats - 1));
      tick();
      if (in_beat_i) in_sent++;
      in_req_ready_i = 1'b0; out_req_ready_i = 1'b0; in_beat_i = 1'b0;
    end
    m_run = 2;
    check("run_in_valid",  in_req_valid_o, 0);
    check("run_out_valid", out_req_valid_o, 0);
    check("run_in_cnt",    dut.u_in_cnt.r_cnt, npre);
    check("run_mode",      dp_mode_o, SFM_DP_MODE_NORM);

    // Normalisation beats
    out_sent = 0;
    while (out_sent < beats) begin
      g = (norm_gap < 0) ? int'($urandom_range(2, 0)) : norm_gap;
      repeat (g) tick();
      out_beat_i = 1'b1;
      in_beat_i  = (in_sent < beats);
      if (in_beat_i) check("norm_last", dp_last_o, (in_sent == beats - 1));
      if (poke && out_sent == 0) begin
        start_i = 1'b1;
        len_i   = LW'(len + VECT * 3 + 1);
      end
      tick();
      if (in_beat_i) in_sent++;
      out_sent++;
      out_beat_i = 1'b0; in_beat_i = 1'b0;
      if (start_i) begin
        start_i = 1'b0;
        check("poke_beats", in_req_beats_o, beats);
        check("poke_strb",  last_strb_o, strb);
      end
    end
    m_run = 0;

    check("done_pulse", done_o, 1);
    check("done_busy",  busy_o, 1);
    check("done_mode",  dp_mode_o, SFM_DP_MODE_IDLE);
    check("done_last",  dp_last_o, 0);
    tick();
    m_busy = 1'b0;
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
    check_perf("job");
    tick();
    tick();
    check_perf("job_hold");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    in_addr_i = '0; out_addr_i = '0; len_i = '0;
    in_req_ready_i = 1'b0; out_req_ready_i = 1'b0;
    in_beat_i = 1'b0; out_beat_i = 1'b0; dp_acc_done_i = 1'b0;
    repeat (2) @(negedge clk_i);

    check("rst_busy",      busy_o, 0);
    check("rst_done",      done_o, 0);
    check("rst_in_valid",  in_req_valid_o, 0);
    check("rst_out_valid", out_req_valid_o, 0);
    check("rst_mode",      dp_mode_o, SFM_DP_MODE_IDLE);
    check("rst_last",      dp_last_o, 0);
    check("rst_beats",     in_req_beats_o, 0);
    check("rst_strb",      last_strb_o, 0);
    check("rst_pbusy",     perf_busy_o, 0);
    check("rst_pstall",    perf_stall_o, 0);
    rst_ni = 1'b1;
    tick();

    // Directed jobs
    run_job(16, 0, 0, 0, 0, 0, 1'b0);
    run_job(13, 0, 0, 10, 0, 0, 1'b0);
    run_job(0, 0, 0, 0, 0, 0, 1'b0);
    run_job(32, 0, 5, 0, 0, 0, 1'b0);

    // Soft clear during accumulation, after one of four beats
    start_i = 1'b1; len_i = 16'd32; in_addr_i = 32'h1000; out_addr_i = 32'h2000;
    tick();
    start_i = 1'b0;
    in_req_ready_i = 1'b1;
    tick();
    in_req_ready_i = 1'b0;
    in_beat_i = 1'b1;
    tick();
    in_beat_i = 1'b0;
    check("clr_pre_busy", busy_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_busy",     busy_o, 0);
    check("clr_done",     done_o, 0);
    check("clr_mode",     dp_mode_o, SFM_DP_MODE_IDLE);
    check("clr_beats",    in_req_beats_o, 0);
    check("clr_strb",     last_strb_o, 0);
    check("clr_addr",     in_req_addr_o, 0);
    check("clr_pbusy",    perf_busy_o, 0);
    tick();
    check("clr_done2",    done_o, 0);
    check("clr_in_valid", in_req_valid_o, 0);
    run_job(8, 0, 0, 0, 0, 0, 1'b0);

    // start_i pulsed during the normalisation run is ignored
    run_job(16, 0, 0, 0, 0, 0, 1'b1);

    // Three-cycle output stall in the normalisation run
    run_job(8, 0, 0, 0, 0, 3, 1'b0);
`ifdef SFM_SCHED_PERF_EN
    check("stall3", perf_stall_o, 3);
`endif

    // Asynchronous reset in the middle of a job
    start_i = 1'b1; len_i = 16'd24; in_addr_i = 32'hABCD; out_addr_i = 32'h1234;
    tick();
    start_i = 1'b0;
    in_req_ready_i = 1'b1;
    tick();
    in_req_ready_i = 1'b0;
    in_beat_i = 1'b1;
    tick();
    in_beat_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy",     busy_o, 0);
    check("arst_valid",    in_req_valid_o | out_req_valid_o, 0);
    check("arst_mode",     dp_mode_o, SFM_DP_MODE_IDLE);
    check("arst_last",     dp_last_o, 0);
    check("arst_beats",    in_req_beats_o, 0);
    check("arst_addr",     in_req_addr_o, 0);
    check("arst_pbusy",    perf_busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) tick();
    check("arst_no_reissue", in_req_valid_o, 0);
    check("arst_idle",       busy_o, 0);

    // Randomised jobs
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(64, 1)), int'($urandom_range(3, 0)),
              int'($urandom_range(4, 0)), int'($urandom_range(5, 0)),
              -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
